// File: rtl/dpram_reader.sv
// Read-side sweeper for one dual_port_ram port: issues a contiguous run of reads and
// streams the returned words through a two-entry buffer onto a valid/ready interface.
module dpram_reader #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [DEPTH-1:0] base_addr,
  input  logic [DEPTH:0]   count,
  input  logic             dir,
  output logic             busy,
  output logic             done,
  output logic [DEPTH-1:0] mem_addr,
  output logic             mem_we,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t           state;
  logic [DEPTH-1:0] next_addr, addr_q, step_addr;
  logic [DEPTH:0]   remaining;
  logic             sweep_dir;
  logic             inflight;
  logic [WIDTH-1:0] buf1;
  logic             v1;
  logic             pop, push, issue;
  logic [1:0]       pending;

  assign mem_we = 1'b0;
  assign pop    = out_valid & out_ready;
  assign push   = inflight;

  // Words held or on their way; a read may issue only if the slot frees up in time.
  assign pending   = {1'b0, out_valid} + {1'b0, v1} + {1'b0, inflight};
  assign issue     = (state == READ) && (remaining != '0) && ((pending - {1'b0, pop}) < 2'd2);
  assign mem_addr  = issue ? next_addr : addr_q;
  assign step_addr = sweep_dir ? next_addr - DEPTH'(1) : next_addr + DEPTH'(1);

  always_ff @(posedge clock) begin
    if (reset_n) begin
      state     <= IDLE;
      next_addr <= '0;
      addr_q    <= '0;
      remaining <= '0;
      sweep_dir <= 1'b0;
      inflight  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      buf1      <= '0;
      v1        <= 1'b0;
    end else begin
      done     <= 1'b0;
      addr_q   <= mem_addr;
      inflight <= issue;

      case (state)
        IDLE: if (start) begin
          if (count == '0) begin
            done <= 1'b1;
          end else begin
            state     <= READ;
            next_addr <= base_addr;
            remaining <= count;
            sweep_dir <= dir;
            busy      <= 1'b1;
          end
        end
        READ: if (issue) begin
          next_addr <= step_addr;
          remaining <= remaining - (DEPTH+1)'(1);
          if (remaining == (DEPTH+1)'(1)) state <= DRAIN;
        end
        DRAIN: if (pop && !v1 && !inflight) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase

      // Head register drives out_data directly; buf1 is the second slot.
      case ({push, pop})
        2'b11: begin
          if (v1) begin
            out_data <= buf1;
            buf1     <= mem_rdata;
          end else begin
            out_data <= mem_rdata;
          end
        end
        2'b10: begin
          if (!out_valid) begin
            out_data  <= mem_rdata;
            out_valid <= 1'b1;
          end else begin
            buf1 <= mem_rdata;
            v1   <= 1'b1;
          end
        end
        2'b01: begin
          out_data  <= buf1;
          out_valid <= v1;
          v1        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/dpram_reader.md
Name: dpram_reader

Overview:
- Read-side companion to the dual-port RAM write path.
- Sweeps a contiguous address range of one dual_port_ram port with write-enable held low.
- Absorbs the RAM's one-cycle synchronous read latency and streams the words out on a valid/ready interface with full backpressure support.
- Sits between a dual_port_ram port and a downstream consumer (checker, output formatter); the other RAM port remains with the writer.

Parameters:
- WIDTH, 8, data bit width; matches the RAM data width.
- DEPTH, 4, address bit width; the RAM holds 2^DEPTH words.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset_n  input  1  synchronous, active-high reset; 1 = reset, sampled on the rising edge of clock.
- start  input  1  one-cycle request to begin a sweep; sampled only in IDLE.
- base_addr  input  DEPTH  first address of the sweep; sampled with start.
- count  input  DEPTH+1  number of words to read, 0..2^DEPTH; sampled with start.
- dir  input  1  0 = ascending addresses (+1), 1 = descending (-1); sampled with start.
- busy  output  1  high from the cycle after start is accepted until the cycle done is asserted.
- done  output  1  one-cycle pulse when the sweep completes.
- mem_addr  output  DEPTH  RAM read address.
- mem_we  output  1  RAM write enable; constant 0.
- mem_rdata  input  WIDTH  RAM read data, valid one cycle after mem_addr is presented.
- out_data  output  WIDTH  streamed word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the word; a transfer occurs when out_valid & out_ready.

Behaviour:
- Reset (reset_n = 1 at a clock edge): state IDLE; busy = 0; done = 0; out_valid = 0; out_data = 0; mem_addr = 0. Buffer and in-flight tracking are cleared. Reset mid-sweep abandons the sweep and discards buffered words; no done pulse is produced.
- States:
  - IDLE: waiting for start.
  - READ: issuing reads.
  - DRAIN: all reads issued; waiting for the buffer to empty.
- IDLE -> READ when start = 1 and count != 0. The block latches next_addr = base_addr and remaining = count.
- IDLE with start = 1 and count = 0: no reads are issued; done pulses in the next cycle; busy stays 0.
- start while busy is ignored.
- Read issue:
  - A read is issued in READ when remaining > 0 and (buffer occupancy + in-flight reads - pop this cycle) < 2.
  - On issue: mem_addr = next_addr that cycle. next_addr steps by +1 or -1 modulo 2^DEPTH (15 -> 0 ascending, 0 -> 15 descending). remaining decrements.
  - mem_addr holds its last value when no read is issued.
- Buffer:
  - Two-entry FIFO.
  - mem_rdata is captured at the end of the cycle after issue.
  - out_data/out_valid are driven from the buffer head, registered.
  - A simultaneous push and pop is legal and leaves occupancy unchanged.
  - The buffer never overflows; the issue rule above guarantees this.
- Word order: out_data follows issue order exactly.
- READ -> DRAIN after the last read is issued (remaining becomes 0).
- DRAIN -> IDLE when the final word transfers. done pulses in the cycle after that final transfer, and busy deasserts in the same cycle as done.
- Latency and throughput:
  - start is high in cycle 0.
  - mem_addr = base_addr in cycle 1.
  - mem_rdata is valid in cycle 2.
  - out_valid first goes high in cycle 3.
  - With out_ready held at 1, throughput is one word per cycle.
- Backpressure: out_valid and out_data stay stable while out_ready = 0. Issue stalls at two outstanding words and resumes in the cycle out_ready returns.
- count = 2^DEPTH reads every address exactly once; the sweep wraps through the address boundary as required.

Test Plan:
- Preload RAM addr i = 8'hA0+i; start, base 0, count 4, dir 0, out_ready = 1 -> out_valid in cycles 3..6 with data A0, A1, A2, A3; done pulses in cycle 7; mem_we never 1.
- start, base 2, count 5, dir 1 -> mem_addr sequence 2, 1, 0, 15, 14; data A2, A1, A0, AF, AE.
- base 0, count 16, dir 0, out_ready toggled 1,0,0,1 repeating -> all 16 words A0..AF delivered once, in order; out_data stable during stalls; at most 2 reads outstanding.
- count = 0 with start -> done pulse in cycle 1; no out_valid; busy stays 0.
- Reset asserted in cycle 4 of a count-8 sweep -> next cycle out_valid = 0, busy = 0, no done; a new start (base 5, count 2) returns A5, A6 correctly.
- start asserted again while busy -> ignored; the original sweep completes unchanged with a single done pulse.
